sos_beacon: RTL and testbench
=============================

Name: sos_beacon

Overview:
- Downstream consumer of the LED blinker's period pulse.
- Takes a single-cycle `tick` strobe from the existing counter/blinker stage and uses it as the Morse time base to flash "SOS" on the board LED.
- One message per `start` request, with standard Morse mark/space ratios.
- Sits between the 50 MHz tick generator and the LED pin.

Parameters:
- UNIT_TICKS, 1: tick pulses per Morse unit (≥1).
- CNT_W, 8: width of the internal unit/tick counter; must hold 7*UNIT_TICKS.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high.
- tick  input  1  single-cycle time-base strobe from upstream counter.
- start  input  1  request one SOS message; level or pulse.
- LED  output  1  Morse output, 1 = lit.
- busy  output  1  high while a message is in progress.
- done  output  1  one-cycle pulse when a message completes.

Behaviour:
- Clock, reset and timing:
  - Clock CLOCK_50; reset is synchronous, active-high. All state updates on posedge CLOCK_50.
  - All outputs registered.
- Reset values: LED=0, busy=0, done=0, state=IDLE, element index=0, counter=0.
- Symbol table: 9 elements, idx 0..8 = dot,dot,dot, dash,dash,dash, dot,dot,dot.
  - Dot mark = 1 unit; dash mark = 3 units.
- Space after element idx:
  - 1 unit for idx not in {2,5,8}.
  - 3 units (letter gap) for idx 2,5.
  - 7 units (word gap) for idx 8.
- Message totals:
  - 15 lit units, 34 total units.
  - LED rising edges per message = 9.
- FSM states:
  - IDLE: LED=0, busy=0. If start=1, next cycle MARK with idx=0, counter=0, LED=1, busy=1.
  - MARK: LED=1. Counter increments on each tick. On the tick that makes the count equal mark_len*UNIT_TICKS, next cycle is SPACE with counter=0 and LED=0.
  - SPACE: LED=0. Counter increments on each tick. On the tick that makes the count equal gap_len*UNIT_TICKS:
    - if idx<8: idx+1, next cycle MARK with LED=1;
    - if idx=8: next cycle IDLE, busy=0, done=1 for exactly one cycle.
- Phase alignment:
  - tick is free-running, so the first unit may be partial; its length is between 0 and 1 tick period short.
  - All later element boundaries coincide with the cycle after a tick.
- Ignored stimulus:
  - tick in IDLE is ignored.
  - start while busy is ignored; no queueing.
  - start and tick asserted in the same IDLE cycle: start is accepted, the tick is not counted.
- done and restart:
  - done is asserted in the first IDLE cycle.
  - start held high at that time begins the next message on the following cycle. The minimum IDLE time between messages is therefore 1 cycle.
- Reset mid-message: immediate return to reset values on the next edge. No done pulse.
- Counter width: counter never exceeds 7*UNIT_TICKS. No wrap inside CNT_W when CNT_W is sized per its parameter rule.

Optional Feature:
- Macro: SOS_BEACON_REPEAT_EN.
- Defined:
  - After the word gap of idx 8, the FSM returns to MARK idx=0 instead of IDLE.
  - done still pulses once per message, on the cycle the new MARK begins.
  - busy stays 1.
  - Looping stops only by reset. start is then only needed once.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package sos_beacon_pkg:
  - state enum {IDLE, MARK, SPACE};
  - constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP=1, LETTER_GAP=3, WORD_GAP=7, N_ELEM=9;
  - 9-bit symbol mask 9'b000111000, where 1 = dash.
- Sub-module sos_unit_timer:
  - inputs: tick, clear, target length in units;
  - outputs: expire pulse;
  - holds the UNIT_TICKS scaling.
- The FSM in sos_beacon instantiates one timer.

Test Plan:
- UNIT_TICKS=1, tick every 4 cycles, one start pulse:
  - 9 LED rising edges;
  - LED high for 15 ticks total;
  - done exactly once, 34 ticks (±1 tick alignment) after start;
  - busy=0 afterward.
- UNIT_TICKS=2, tick every 3 cycles:
  - first dash lasts 6 ticks = 18 cycles;
  - letter gap after idx 2 lasts 6 ticks;
  - word gap lasts 14 ticks.
- start re-pulsed at idx 4 and held high through the message:
  - no disturbance to the sequence;
  - next message starts the cycle after done.
- Reset asserted for 1 cycle during dash idx 3:
  - next cycle LED=0, busy=0, done=0;
  - no further LED activity without start.
- start and tick coincident in IDLE:
  - LED=1 next cycle;
  - first mark ends on the following tick, not the coincident one.
- With SOS_BEACON_REPEAT_EN, one start:
  - done pulses every 34 ticks for 3 messages;
  - busy stays 1 throughout.

Source files
------------

// File: rtl/sos_beacon_pkg.sv
// Shared types and Morse constants for the SOS beacon.
// Holds the 9-element S-O-S symbol table and the mark/space lengths in Morse units.
// Helper functions map an element index to its mark length and its following space length.
package sos_beacon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int SYM_GAP    = 1;
  localparam int LETTER_GAP = 3;
  localparam int WORD_GAP   = 7;
  localparam int N_ELEM     = 9;

  // Element index width (0..8) and unit-length width (lengths up to 7 units).
  localparam int IDX_W = 4;
  localparam int LEN_W = 3;

  // A set bit marks a dash; element 0 is the LSB.
  localparam logic [N_ELEM-1:0] SYM_MASK = 9'b000111000;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  // Lit length of element idx, in units.
  function automatic logic [LEN_W-1:0] mark_units(input logic [IDX_W-1:0] i_idx);
    return SYM_MASK[i_idx] ? LEN_W'(DASH_UNITS) : LEN_W'(DOT_UNITS);
  endfunction

  // Dark length after element idx: word gap after the last element,
  // letter gap at the end of each of the first two letters, else symbol gap.
  function automatic logic [LEN_W-1:0] gap_units(input logic [IDX_W-1:0] i_idx);
    if (i_idx == LAST_IDX)
      return LEN_W'(WORD_GAP);
    else if (i_idx == IDX_W'(2) || i_idx == IDX_W'(5))
      return LEN_W'(LETTER_GAP);
    else
      return LEN_W'(SYM_GAP);
  endfunction

endpackage

// File: rtl/sos_unit_timer.sv
// Tick counter that measures one Morse mark or space of i_units * UNIT_TICKS ticks.
// o_expire is combinational: it is high on the tick that completes the interval.
// No backpressure; i_clear holds the count at zero and suppresses expiry.
module sos_unit_timer
  import sos_beacon_pkg::*;
#(
  parameter int UNIT_TICKS = 1,
  parameter int CNT_W      = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_clear,
  input  logic [LEN_W-1:0] i_units,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_target  = CNT_W'(i_units) * CNT_W'(UNIT_TICKS);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign o_expire  = i_tick && !i_clear && (w_cnt_inc == w_target);

  // Count ticks; restart from zero when the interval completes so the next
  // element is timed from the cycle after the expiring tick.
  always_ff @(posedge CLOCK_50) begin
    if (reset || i_clear)
      r_cnt <= '0;
    else if (i_tick)
      r_cnt <= o_expire ? '0 : w_cnt_inc;
  end

endmodule

// File: rtl/sos_beacon.sv
// Flashes one "SOS" on LED per start request, timed by the upstream tick strobe.
// Outputs registered; LED/busy/done change one cycle after the deciding edge inputs.
// start is ignored while busy; SOS_BEACON_REPEAT_EN makes the message loop until reset.
module sos_beacon
  import sos_beacon_pkg::*;
#(
  parameter int UNIT_TICKS = 1,
  parameter int CNT_W      = 8
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tick,
  input  logic start,
  output logic LED,
  output logic busy,
  output logic done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_led;
  logic             w_led_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_clear;
  logic [LEN_W-1:0] w_units;
  logic             w_expire;

  sos_unit_timer #(
    .UNIT_TICKS(UNIT_TICKS),
    .CNT_W     (CNT_W)
  ) u_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .i_tick  (tick),
    .i_clear (w_clear),
    .i_units (w_units),
    .o_expire(w_expire)
  );

  // State, element index and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state and output values; the timer is held clear in IDLE so a tick
  // coincident with the accepted start is not counted.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_led_nxt   = r_led;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_clear     = 1'b0;
    w_units     = mark_units(r_idx);
    case (r_state)
      IDLE: begin
        w_clear    = 1'b1;
        w_led_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt = MARK;
          w_idx_nxt   = '0;
          w_led_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      MARK: begin
        w_units = mark_units(r_idx);
        if (w_expire) begin
          w_state_nxt = SPACE;
          w_led_nxt   = 1'b0;
        end
      end
      SPACE: begin
        w_units = gap_units(r_idx);
        if (w_expire) begin
          if (r_idx == LAST_IDX) begin
            w_done_nxt = 1'b1;
`ifdef SOS_BEACON_REPEAT_EN
            w_state_nxt = MARK;
            w_idx_nxt   = '0;
            w_led_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
`else
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_led_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
`endif
          end else begin
            w_state_nxt = MARK;
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_led_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_led_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign LED  = r_led;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_sos_beacon.sv
// Bench for sos_beacon: instance 0 has UNIT_TICKS=1 with a tick every 4 cycles,
// instance 1 has UNIT_TICKS=2 with a tick every 3 cycles. A unit-schedule model
// scores LED/busy/done every cycle; directed sequences cover the corner cases.
module tb_sos_beacon;

  logic       CLOCK_50 = 1'b0;
  logic [1:0] rst;
  logic [1:0] tick;
  logic [1:0] start;
  logic [1:0] led;
  logic [1:0] busy;
  logic [1:0] done;

  int n_vec = 0;
  int n_err = 0;

  // Lit pattern of one message, one entry per Morse unit (34 units, 15 lit).
  logic [0:33] units;

  always #10 CLOCK_50 = ~CLOCK_50;

  sos_beacon #(.UNIT_TICKS(1), .CNT_W(8)) u_dut0 (
    .CLOCK_50(CLOCK_50), .reset(rst[0]), .tick(tick[0]), .start(start[0]),
    .LED(led[0]), .busy(busy[0]), .done(done[0])
  );

  sos_beacon #(.UNIT_TICKS(2), .CNT_W(8)) u_dut1 (
    .CLOCK_50(CLOCK_50), .reset(rst[1]), .tick(tick[1]), .start(start[1]),
    .LED(led[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #3;
  endtask

  // Free-running tick strobes, updated just after each edge for the next edge.
  int tcnt0 = 0;
  int tcnt1 = 0;
  always @(posedge CLOCK_50) begin
    #1;
    tcnt0 = (tcnt0 + 1 >= 4) ? 0 : tcnt0 + 1;
    tcnt1 = (tcnt1 + 1 >= 3) ? 0 : tcnt1 + 1;
    tick[0] = (tcnt0 == 0);
    tick[1] = (tcnt1 == 0);
  end

  // Reference model: count accepted ticks since start and look up the unit pattern.
  logic [2:0] sb_q[$];
  bit         m_act[2];
  int         m_n[2];
  bit         m_done;
  int         m_u;
  always @(posedge CLOCK_50) begin
    for (int k = 0; k < 2; k++) begin
      m_u    = k + 1;
      m_done = 1'b0;
      if (rst[k]) begin
        m_act[k] = 1'b0;
        m_n[k]   = 0;
      end else if (!m_act[k]) begin
        if (start[k]) begin
          m_act[k] = 1'b1;
          m_n[k]   = 0;
        end
      end else if (tick[k]) begin
        m_n[k]++;
        if (m_n[k] == 34 * m_u) begin
          m_done = 1'b1;
          m_n[k] = 0;
`ifndef SOS_BEACON_REPEAT_EN
          m_act[k] = 1'b0;
`endif
        end
      end
      sb_q.push_back({m_act[k] && units[m_n[k] / m_u], m_act[k], m_done});
    end
  end

  // Scoreboard: compare each registered output set after the edge.
  logic [2:0] mon_exp;
  logic [2:0] mon_act;
  always @(posedge CLOCK_50) begin
    #3;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_inst%0d: got empty scoreboard, expected an entry", k);
      end else begin
        mon_exp = sb_q.pop_front();
        mon_act = {led[k], busy[k], done[k]};
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL sb_inst%0d: got led/busy/done=%b, expected %b (t=%0t)",
                   k, mon_act, mon_exp, $time);
        end
      end
    end
  end

  // Run instance k from an accepted start until busy drops; collect statistics.
  task automatic run_msg(input int k, output int rises, output int lit_t,
                         output int busy_t, output int dones, output int ok);
    int   g;
    logic pl;
    rises  = 0;
    lit_t  = 0;
    busy_t = 0;
    dones  = 0;
    g      = 0;
    pl     = 1'b0;
    if (led[k]) rises++;
    pl = led[k];
    while (busy[k] && g < 3000) begin
      if (tick[k]) begin
        busy_t++;
        if (led[k]) lit_t++;
      end
      step();
      g++;
      if (led[k] && !pl) rises++;
      pl = led[k];
      if (done[k]) dones++;
    end
    ok = (g < 3000) ? 1 : 0;
  endtask

  typedef struct {
    int mark_t;
    int gap_t;
    int mark_c;
  } elem_vec_t;

  elem_vec_t tbl[9];

  initial begin
    int   rises, lit_t, busy_t, dones, ok, g, mt, mc, gt, gc, cnt, nd;
    logic pl;

    units = 34'b1010100011101110111000101010000000;
    rst   = 2'b11;
    tick  = 2'b00;
    start = 2'b00;
    step();
    step();
    check("reset_led0", led[0], 0);
    check("reset_busy0", busy[0], 0);
    check("reset_done1", done[1], 0);
    rst = 2'b00;
    repeat (5) step();

    // Element durations, UNIT_TICKS=2, tick period 3 cycles. Element 0 may be
    // phase-shortened in cycles, so its cycle length is not checked.
    tbl[0] = '{2, 2, -1};
    tbl[1] = '{2, 2, 6};
    tbl[2] = '{2, 6, 6};
    tbl[3] = '{6, 2, 18};
    tbl[4] = '{6, 2, 18};
    tbl[5] = '{6, 6, 18};
    tbl[6] = '{2, 2, 6};
    tbl[7] = '{2, 2, 6};
    tbl[8] = '{2, 14, 6};
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int e = 0; e < 9; e++) begin
      mt = 0; mc = 0; gt = 0; gc = 0; g = 0;
      while (led[1] && g < 100) begin
        if (tick[1]) mt++;
        mc++;
        g++;
        step();
      end
      while (!led[1] && busy[1] && g < 200) begin
        if (tick[1]) gt++;
        gc++;
        g++;
        step();
      end
      check($sformatf("u2_e%0d_mark_ticks", e), mt, tbl[e].mark_t);
      check($sformatf("u2_e%0d_gap_ticks", e), gt, tbl[e].gap_t);
      check($sformatf("u2_e%0d_gap_cycles", e), gc, tbl[e].gap_t * 3);
      if (tbl[e].mark_c >= 0)
        check($sformatf("u2_e%0d_mark_cycles", e), mc, tbl[e].mark_c);
    end

`ifdef SOS_BEACON_REPEAT_EN
    // One start, three back-to-back messages 34 ticks apart, busy never drops.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    busy_t = 0; nd = 0; cnt = 0; g = 0;
    while (nd < 3 && g < 3000) begin
      if (tick[0] && busy[0]) busy_t++;
      step();
      g++;
      if (!busy[0]) cnt++;
      if (done[0]) begin
        nd++;
        check($sformatf("rep_interval%0d", nd), busy_t, 34);
        busy_t = 0;
      end
    end
    check("rep_three_dones", nd, 3);
    check("rep_busy_low_cycles", cnt, 0);
    rst = 2'b11;
    step();
    rst = 2'b00;
    check("rep_reset_busy", busy[0], 0);
`else
    // Single message, UNIT_TICKS=1, tick every 4 cycles.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    run_msg(0, rises, lit_t, busy_t, dones, ok);
    check("msg1_finished", ok, 1);
    check("msg1_led_rises", rises, 9);
    check("msg1_lit_ticks", lit_t, 15);
    check("msg1_ticks_to_done", busy_t, 34);
    check("msg1_done_count", dones, 1);
    check("msg1_done_at_idle", done[0], 1);
    cnt = 0;
    repeat (20) begin
      step();
      if (busy[0] || done[0]) cnt++;
    end
    check("msg1_quiet_after", cnt, 0);

    // start re-pulsed at element 4 and then held: no disturbance, restart right after done.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    rises = 1; pl = 1'b1; g = 0;
    while (rises < 5 && g < 500) begin
      step();
      g++;
      if (led[0] && !pl) rises++;
      pl = led[0];
    end
    check("hold_reach_e4", rises, 5);
    start[0] = 1'b1;
    g = 0;
    while (busy[0] && g < 1000) begin
      step();
      g++;
    end
    check("hold_done_seen", done[0], 1);
    step();
    check("hold_restart_busy", busy[0], 1);
    check("hold_restart_led", led[0], 1);
    start[0] = 1'b0;
    run_msg(0, rises, lit_t, busy_t, dones, ok);
    check("hold_msg2_rises", rises, 9);
    check("hold_msg2_ticks", busy_t, 34);
    repeat (3) step();

    // Reset for one cycle during the dash of element 3.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    rises = 1; pl = 1'b1; g = 0;
    while (rises < 4 && g < 500) begin
      step();
      g++;
      if (led[0] && !pl) rises++;
      pl = led[0];
    end
    check("rst_reach_e3", rises, 4);
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("rst_led", led[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    cnt = 0;
    repeat (200) begin
      step();
      if (led[0] || busy[0] || done[0]) cnt++;
    end
    check("rst_no_activity", cnt, 0);

    // start coincident with a tick in IDLE: that tick must not shorten the first dot.
    g = 0;
    while (!tick[0] && g < 10) begin
      step();
      g++;
    end
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("coinc_led_on", led[0], 1);
    mc = 0; g = 0;
    while (led[0] && g < 50) begin
      mc++;
      g++;
      step();
    end
    check("coinc_first_mark_cycles", mc, 4);
    run_msg(0, rises, lit_t, busy_t, dones, ok);
    check("coinc_msg_done", dones, 1);
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
